pkt_ingress_gate: RTL and testbench
===================================

Name: pkt_ingress_gate

Overview:
Packet admission stage placed directly upstream of the buffer write port. It drives the buffer's s_wdata/s_wvalid/s_wready/s_wlast/s_wsideband. Whole packets are admitted or dropped on their first beat, based on flow id and a per-flow enable mask. Admitted packets longer than MAX_BEATS are truncated, so no packet can run away with the segment pool.

Parameters:
DATA_WIDTH, 1024, data beat width in bits
SB_WIDTH, 10, sideband width; the full sideband value is the flow id
NUM_FLOWS, 16, number of valid flows; ids >= NUM_FLOWS are illegal; range 1..2^SB_WIDTH
MAX_BEATS, 256, max beats forwarded per packet; >= 2
CNT_W, 32, width of statistics counters

Ports:
clk  in  1  single clock
rstn  in  1  asynchronous active-low reset
in_wdata  in  DATA_WIDTH  source data
in_wvalid  in  1  source valid
in_wready  out  1  ready to source
in_wlast  in  1  last beat of packet
in_wsideband  in  SB_WIDTH  flow id; meaningful on first beat only
flow_enable  in  NUM_FLOWS  per-flow admit mask, quasi-static
out_wdata  out  DATA_WIDTH  data to buffer
out_wvalid  out  1  valid to buffer
out_wready  in  1  buffer s_wready
out_wlast  out  1  last beat to buffer
out_wsideband  out  SB_WIDTH  latched flow id of current packet
drop_pulse  out  1  one-cycle pulse when a packet's first beat is dropped
pass_pkt_cnt  out  CNT_W  packets admitted (macro only)
drop_pkt_cnt  out  CNT_W  packets dropped (macro only)
trunc_pkt_cnt  out  CNT_W  packets truncated (macro only)

Behaviour:
- Reset is asynchronous, active-low, and is asserted by rstn=0. All state goes to IDLE.
- Reset values: out_wvalid=0, out_wlast=0, out_wdata=0, out_wsideband=0, drop_pulse=0, all counters=0, beat_cnt=0.
- Reset mid-packet abandons the packet. The remainder of that packet is then treated as a new packet by the source side; the source is responsible for resynchronising.
- Output stage: a single register.
  - Accept = in_wvalid && in_wready.
  - Latency is 1 cycle from accept to out_wvalid.
  - out_* hold stable while out_wvalid && !out_wready.
  - out_wvalid clears when the beat is taken and no new beat is accepted in the same cycle.
- in_wready:
  - IDLE/PASS: (!out_wvalid || out_wready). Combinational, giving full throughput.
  - DROP/TRUNC: 1. Discarded beats are sunk at line rate.
- Admit condition, evaluated on the first-beat accept in IDLE: (in_wsideband < NUM_FLOWS) && flow_enable[in_wsideband]. flow_enable changes during a packet affect the next packet only.
- FSM states: IDLE, PASS, DROP, TRUNC.
- IDLE, accept:
  - Admit: forward the beat and latch out_wsideband. beat_cnt=1. Next state is IDLE if in_wlast, else PASS.
  - Reject: no output. drop_pulse=1 for one cycle. Next state is IDLE if in_wlast, else DROP.
- PASS, accept:
  - Forward the beat and increment beat_cnt.
  - If in_wlast: go to IDLE.
  - Else if beat_cnt==MAX_BEATS-1 (this beat is beat MAX_BEATS): forward with out_wlast forced to 1 and go to TRUNC.
- DROP, accept: discard the beat; on in_wlast go to IDLE.
- TRUNC, accept: discard the beat; on in_wlast go to IDLE.
- A packet of exactly MAX_BEATS beats is not truncated: its own last coincides with the limit.
- A single-beat packet (first beat with in_wlast=1) returns to IDLE with no intermediate state.
- beat_cnt width is $clog2(MAX_BEATS+1). It clears on entry to IDLE.
- out_wsideband is constant for all beats of a forwarded packet.

Optional Feature:
Macro: PKT_INGRESS_GATE_STATS_EN.
- Defined:
  - pass_pkt_cnt increments on each admitted first beat.
  - drop_pkt_cnt increments on each rejected first beat.
  - trunc_pkt_cnt increments on each PASS->TRUNC transition.
  - All three saturate at all-ones and never wrap.
- Undefined: the three counter ports are tied to 0 and no counter flops are built. drop_pulse remains in both cases.

Test Plan:
- Reset: rstn low asynchronously with clk stopped -> all outputs 0 immediately. After release, a 4-beat packet on flow 3 with flow_enable=16'hFFFF is forwarded 1 cycle later, with out_wsideband=3 on all 4 beats and out_wlast on beat 4.
- Reject: flow 5 with flow_enable[5]=0, 3-beat packet -> no out_wvalid, in_wready=1 throughout, drop_pulse once. drop_pkt_cnt=1 with the macro defined.
- Illegal id: sideband=20 with NUM_FLOWS=16, 1-beat packet -> dropped, state stays IDLE. The next packet on flow 0 passes back-to-back with no bubble.
- Truncation: MAX_BEATS=4, 7-beat packet on flow 1 -> 4 beats out with out_wlast on beat 4. Beats 5-7 are sunk and trunc_pkt_cnt=1. An exactly 4-beat packet -> no truncation.
- Backpressure: out_wready low for 5 cycles mid-packet -> out_* stable and in_wready=0 during the stall. No beat lost or duplicated; data order is preserved (compare against a scoreboard).
- Saturation (macro): CNT_W=4, 17 admitted packets -> pass_pkt_cnt holds at 15.

Source files
------------

// File: rtl/pkt_ingress_gate.sv
// Packet admission gate in front of the buffer write port: admits or drops whole packets by flow id and truncates long ones.
// Optional saturating statistics counters are built when PKT_INGRESS_GATE_STATS_EN is defined.
module pkt_ingress_gate #(
    parameter int DATA_WIDTH = 1024,
    parameter int SB_WIDTH   = 10,
    parameter int NUM_FLOWS  = 16,
    parameter int MAX_BEATS  = 256,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] in_wdata,
    input  logic                  in_wvalid,
    output logic                  in_wready,
    input  logic                  in_wlast,
    input  logic [SB_WIDTH-1:0]   in_wsideband,
    input  logic [NUM_FLOWS-1:0]  flow_enable,
    output logic [DATA_WIDTH-1:0] out_wdata,
    output logic                  out_wvalid,
    input  logic                  out_wready,
    output logic                  out_wlast,
    output logic [SB_WIDTH-1:0]   out_wsideband,
    output logic                  drop_pulse,
    output logic [CNT_W-1:0]      pass_pkt_cnt,
    output logic [CNT_W-1:0]      drop_pkt_cnt,
    output logic [CNT_W-1:0]      trunc_pkt_cnt
);

    localparam int                  BCW        = $clog2(MAX_BEATS + 1);
    localparam logic [BCW-1:0]      BEAT_LIMIT = BCW'(MAX_BEATS - 1);
    localparam logic [SB_WIDTH:0]   FLOW_COUNT = (SB_WIDTH + 1)'(NUM_FLOWS);

    typedef enum logic [1:0] {IDLE, PASS, DROP, TRUNC} state_t;

    state_t                  state_reg, state_next;
    logic [BCW-1:0]          beat_cnt_reg, beat_cnt_next;
    logic [DATA_WIDTH-1:0]   out_wdata_reg, out_wdata_next;
    logic                    out_wvalid_reg, out_wvalid_next;
    logic                    out_wlast_reg, out_wlast_next;
    logic [SB_WIDTH-1:0]     out_wsideband_reg, out_wsideband_next;
    logic                    drop_pulse_reg, drop_pulse_next;

    logic [NUM_FLOWS-1:0]    flow_match;
    logic                    id_legal;
    logic                    admit;
    logic                    accept;

    // One-hot decode of the id against the mask; ids beyond NUM_FLOWS never match.
    generate
        for (genvar gi = 0; gi < NUM_FLOWS; gi++) begin : g_flow_match
            assign flow_match[gi] = (in_wsideband == SB_WIDTH'(gi)) && flow_enable[gi];
        end
    endgenerate

    assign id_legal = ({1'b0, in_wsideband} < FLOW_COUNT);
    assign admit    = id_legal && (|flow_match);

    always_comb begin
        in_wready = !out_wvalid_reg || out_wready;
        if (state_reg == DROP || state_reg == TRUNC) begin
            in_wready = 1'b1;
        end
    end

    assign accept = in_wvalid && in_wready;

    always_comb begin
        state_next         = state_reg;
        beat_cnt_next      = beat_cnt_reg;
        out_wvalid_next    = out_wvalid_reg && !out_wready;
        out_wdata_next     = out_wdata_reg;
        out_wlast_next     = out_wlast_reg;
        out_wsideband_next = out_wsideband_reg;
        drop_pulse_next    = 1'b0;

        if (accept) begin
            case (state_reg)
                IDLE: begin
                    if (admit) begin
                        out_wvalid_next    = 1'b1;
                        out_wdata_next     = in_wdata;
                        out_wlast_next     = in_wlast;
                        out_wsideband_next = in_wsideband;
                        state_next         = in_wlast ? IDLE : PASS;
                        beat_cnt_next      = in_wlast ? '0 : BCW'(1);
                    end else begin
                        drop_pulse_next = 1'b1;
                        state_next      = in_wlast ? IDLE : DROP;
                        beat_cnt_next   = '0;
                    end
                end
                PASS: begin
                    out_wvalid_next = 1'b1;
                    out_wdata_next  = in_wdata;
                    if (in_wlast) begin
                        out_wlast_next = 1'b1;
                        state_next     = IDLE;
                        beat_cnt_next  = '0;
                    end else if (beat_cnt_reg == BEAT_LIMIT) begin
                        // Limit reached mid-packet: close it off downstream and sink the rest.
                        out_wlast_next = 1'b1;
                        state_next     = TRUNC;
                        beat_cnt_next  = beat_cnt_reg + 1'b1;
                    end else begin
                        out_wlast_next = 1'b0;
                        beat_cnt_next  = beat_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    if (in_wlast) begin
                        state_next    = IDLE;
                        beat_cnt_next = '0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg         <= IDLE;
            beat_cnt_reg      <= '0;
            out_wdata_reg     <= '0;
            out_wvalid_reg    <= 1'b0;
            out_wlast_reg     <= 1'b0;
            out_wsideband_reg <= '0;
            drop_pulse_reg    <= 1'b0;
        end else begin
            state_reg         <= state_next;
            beat_cnt_reg      <= beat_cnt_next;
            out_wdata_reg     <= out_wdata_next;
            out_wvalid_reg    <= out_wvalid_next;
            out_wlast_reg     <= out_wlast_next;
            out_wsideband_reg <= out_wsideband_next;
            drop_pulse_reg    <= drop_pulse_next;
        end
    end

    assign out_wdata     = out_wdata_reg;
    assign out_wvalid    = out_wvalid_reg;
    assign out_wlast     = out_wlast_reg;
    assign out_wsideband = out_wsideband_reg;
    assign drop_pulse    = drop_pulse_reg;

`ifdef PKT_INGRESS_GATE_STATS_EN
    logic [2:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_reg [3];

    assign cnt_inc[0] = accept && (state_reg == IDLE) && admit;
    assign cnt_inc[1] = accept && (state_reg == IDLE) && !admit;
    assign cnt_inc[2] = accept && (state_reg == PASS) && !in_wlast && (beat_cnt_reg == BEAT_LIMIT);

    // Saturating event counters: pass, drop, truncate.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_stat_cnt
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    cnt_reg[gi] <= '0;
                end else if (cnt_inc[gi] && !(&cnt_reg[gi])) begin
                    cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
                end
            end
        end
    endgenerate

    assign pass_pkt_cnt  = cnt_reg[0];
    assign drop_pkt_cnt  = cnt_reg[1];
    assign trunc_pkt_cnt = cnt_reg[2];
`else
    assign pass_pkt_cnt  = '0;
    assign drop_pkt_cnt  = '0;
    assign trunc_pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_pkt_ingress_gate.sv
// Directed bench for pkt_ingress_gate: reset, admit/reject, illegal id, truncation, backpressure, counter saturation.
module tb_pkt_ingress_gate;

    localparam int DW  = 32;
    localparam int SBW = 10;
    localparam int NF  = 16;
    localparam int MB  = 4;
    localparam int CW  = 4;
`ifdef PKT_INGRESS_GATE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           clk_en = 1'b0;
    logic           rstn = 1'b1;
    logic [DW-1:0]  in_wdata = '0;
    logic           in_wvalid = 1'b0;
    logic           in_wready;
    logic           in_wlast = 1'b0;
    logic [SBW-1:0] in_wsideband = '0;
    logic [NF-1:0]  flow_enable = 16'hFFFF;
    logic [DW-1:0]  out_wdata;
    logic           out_wvalid;
    logic           out_wready = 1'b1;
    logic           out_wlast;
    logic [SBW-1:0] out_wsideband;
    logic           drop_pulse;
    logic [CW-1:0]  pass_pkt_cnt, drop_pkt_cnt, trunc_pkt_cnt;

    int checks = 0;
    int errors = 0;
    int drop_seen = 0;
    int w;

    typedef struct {
        logic [DW-1:0]  d;
        logic [SBW-1:0] sb;
        logic           last;
    } beat_t;
    beat_t exp_q[$];
    beat_t mon_e;

    pkt_ingress_gate #(
        .DATA_WIDTH(DW), .SB_WIDTH(SBW), .NUM_FLOWS(NF), .MAX_BEATS(MB), .CNT_W(CW)
    ) dut (
        .clk(clk), .rstn(rstn),
        .in_wdata(in_wdata), .in_wvalid(in_wvalid), .in_wready(in_wready),
        .in_wlast(in_wlast), .in_wsideband(in_wsideband), .flow_enable(flow_enable),
        .out_wdata(out_wdata), .out_wvalid(out_wvalid), .out_wready(out_wready),
        .out_wlast(out_wlast), .out_wsideband(out_wsideband), .drop_pulse(drop_pulse),
        .pass_pkt_cnt(pass_pkt_cnt), .drop_pkt_cnt(drop_pkt_cnt), .trunc_pkt_cnt(trunc_pkt_cnt)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] d, input logic [SBW-1:0] sb, input logic last);
        beat_t b;
        b.d = d; b.sb = sb; b.last = last;
        exp_q.push_back(b);
    endtask

    task automatic send(input logic [DW-1:0] d, input logic [SBW-1:0] sb, input logic last,
                        output int waits);
        in_wvalid = 1'b1; in_wdata = d; in_wsideband = sb; in_wlast = last;
        waits = 0;
        @(negedge clk);
        while (in_wready !== 1'b1 && waits < 40) begin
            @(negedge clk);
            waits++;
        end
        if (in_wready !== 1'b1) check("accept_timeout", {31'b0, in_wready}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_wvalid = 1'b0; in_wlast = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Output monitor: every beat handed to the buffer must match the next expected beat.
    always @(negedge clk) begin
        if (rstn && drop_pulse === 1'b1) drop_seen++;
        if (rstn && out_wvalid === 1'b1 && out_wready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", out_wdata, 32'hDEAD_BEEF ^ out_wdata ^ 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                check("beat_data", out_wdata, mon_e.d);
                check("beat_sb", {22'b0, out_wsideband}, {22'b0, mon_e.sb});
                check("beat_last", {31'b0, out_wlast}, {31'b0, mon_e.last});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Asynchronous reset with the clock stopped
        #3 rstn = 1'b0;
        #2;
        check("rst_wvalid", {31'b0, out_wvalid}, 32'd0);
        check("rst_wlast", {31'b0, out_wlast}, 32'd0);
        check("rst_wdata", out_wdata, 32'd0);
        check("rst_wsb", {22'b0, out_wsideband}, 32'd0);
        check("rst_drop", {31'b0, drop_pulse}, 32'd0);
        check("rst_ready", {31'b0, in_wready}, 32'd1);
        check("rst_cnts", {20'b0, pass_pkt_cnt, drop_pkt_cnt, trunc_pkt_cnt}, 32'd0);
        clk_en = 1'b1;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;

        // 4-beat packet on flow 3, one cycle latency
        for (int i = 0; i < 4; i++) push(32'h0300_0000 + i, 10'd3, i == 3);
        send(32'h0300_0000, 10'd3, 1'b0, w);
        check("lat_valid", {31'b0, out_wvalid}, 32'd1);
        check("lat_data", out_wdata, 32'h0300_0000);
        for (int i = 1; i < 4; i++) send(32'h0300_0000 + i, 10'd3, i == 3, w);
        idle(2);
        check("q_empty_pass", exp_q.size(), 32'd0);

        // Reject flow 5: sunk at line rate, single drop pulse
        flow_enable = 16'hFFDF;
        for (int i = 0; i < 3; i++) begin
            send(32'h0500_0000 + i, 10'd5, i == 2, w);
            check("rej_ready", w, 32'd0);
        end
        idle(2);
        check("rej_drop_pulses", drop_seen, 32'd1);
        check("rej_drop_cnt", {28'b0, drop_pkt_cnt}, STATS ? 32'd1 : 32'd0);

        // Illegal id 20, then flow 0 back-to-back
        flow_enable = 16'hFFFF;
        push(32'h0000_0010, 10'd0, 1'b0);
        push(32'h0000_0011, 10'd0, 1'b1);
        send(32'h1400_0000, 10'd20, 1'b1, w);
        send(32'h0000_0010, 10'd0, 1'b0, w);
        check("no_bubble", w, 32'd0);
        check("b2b_valid", {31'b0, out_wvalid}, 32'd1);
        send(32'h0000_0011, 10'd0, 1'b1, w);
        idle(2);
        check("illegal_drop_pulses", drop_seen, 32'd2);

        // 7-beat packet truncated to 4, then an exact 4-beat packet
        for (int i = 0; i < 4; i++) push(32'h0100_0000 + i, 10'd1, i == 3);
        for (int i = 0; i < 7; i++) send(32'h0100_0000 + i, 10'd1, i == 6, w);
        idle(2);
        check("trunc_cnt1", {28'b0, trunc_pkt_cnt}, STATS ? 32'd1 : 32'd0);
        for (int i = 0; i < 4; i++) push(32'h0110_0000 + i, 10'd1, i == 3);
        for (int i = 0; i < 4; i++) send(32'h0110_0000 + i, 10'd1, i == 3, w);
        idle(2);
        check("trunc_cnt_exact", {28'b0, trunc_pkt_cnt}, STATS ? 32'd1 : 32'd0);
        check("q_empty_trunc", exp_q.size(), 32'd0);

        // Backpressure: 5-cycle stall holding beat 2 of flow 2
        for (int i = 0; i < 4; i++) push(32'h0200_0000 + i, 10'd2, i == 3);
        send(32'h0200_0000, 10'd2, 1'b0, w);
        send(32'h0200_0001, 10'd2, 1'b0, w);
        out_wready = 1'b0;
        in_wvalid = 1'b1; in_wdata = 32'h0200_0002; in_wlast = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("stall_valid", {31'b0, out_wvalid}, 32'd1);
            check("stall_data", out_wdata, 32'h0200_0001);
            check("stall_sb", {22'b0, out_wsideband}, 32'd2);
            check("stall_ready", {31'b0, in_wready}, 32'd0);
        end
        @(posedge clk); #1;
        out_wready = 1'b1;
        send(32'h0200_0002, 10'd2, 1'b0, w);
        send(32'h0200_0003, 10'd2, 1'b1, w);
        idle(2);
        check("q_empty_bp", exp_q.size(), 32'd0);
        check("pass_cnt5", {28'b0, pass_pkt_cnt}, STATS ? 32'd5 : 32'd0);

        // 12 more admitted packets: 17 total saturates a 4-bit counter
        for (int i = 0; i < 12; i++) begin
            push(32'h0700_0000 + i, 10'd7, 1'b1);
            send(32'h0700_0000 + i, 10'd7, 1'b1, w);
        end
        idle(2);
        check("pass_cnt_sat", {28'b0, pass_pkt_cnt}, STATS ? 32'd15 : 32'd0);
        check("drop_cnt2", {28'b0, drop_pkt_cnt}, STATS ? 32'd2 : 32'd0);

        // Reset mid-packet with the clock stopped; remainder becomes a new packet
        push(32'h0400_0000, 10'd4, 1'b0);
        send(32'h0400_0000, 10'd4, 1'b0, w);
        @(negedge clk);
        clk_en = 1'b0;
        in_wvalid = 1'b0;
        #2 rstn = 1'b0;
        #1;
        check("midrst_valid", {31'b0, out_wvalid}, 32'd0);
        check("midrst_data", out_wdata, 32'd0);
        check("midrst_sb", {22'b0, out_wsideband}, 32'd0);
        check("midrst_pass_cnt", {28'b0, pass_pkt_cnt}, 32'd0);
        clk_en = 1'b1;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        push(32'h0400_0001, 10'd4, 1'b1);
        send(32'h0400_0001, 10'd4, 1'b1, w);
        idle(3);
        check("q_empty_end", exp_q.size(), 32'd0);
        check("pass_cnt_after_rst", {28'b0, pass_pkt_cnt}, STATS ? 32'd1 : 32'd0);
        check("drop_pulses_end", drop_seen, 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
